// File: rtl/csa_stage_multiplier_pkg.sv
// Shared sizing constants for the carry-save multiplier.
// Result width carries one extra bit so the CPA carry chain is visible.
package mult_pkg;
  localparam int MULT_WIDTH = 64;
  localparam int PROD_W     = 2 * MULT_WIDTH;
  localparam int RES_W      = PROD_W + 1;
endpackage

// File: rtl/csa_stage_multiplier_csa_3to2.sv
// Bitwise 3:2 compressor: one full adder per bit, no carry propagation.
module csa_3to2 #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/csa_stage_multiplier.sv
// Unsigned WIDTH x WIDTH multiplier: AND partial products, linear CSA chain,
// final carry-propagate add, one output register stage.
module csa_stage_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH:0]   result,
  output logic               cout
);
  localparam int P_W    = 2 * WIDTH;
  localparam int R_W    = P_W + 1;
  localparam int STAGES = WIDTH - 2;

  // Vectors are kept at R_W so carry<<1 never drops a bit inside the chain.
  logic [R_W-1:0] w_pp [WIDTH];
  logic [R_W-1:0] w_s  [STAGES];
  logic [R_W-1:0] w_c  [STAGES];
  logic [R_W:0]   w_cpa;

  logic             r_out_valid;
  logic [R_W-1:0]   r_result;
  logic             r_cout;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign w_pp[i] = {{(R_W - WIDTH){1'b0}}, a & {WIDTH{b[i]}}} << i;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      csa_3to2 #(.N(R_W)) u_csa (
        .x (w_pp[0]),
        .y (w_pp[1]),
        .z (w_pp[2]),
        .s (w_s[k]),
        .c (w_c[k])
      );
    end else begin : g_next
      csa_3to2 #(.N(R_W)) u_csa (
        .x (w_s[k-1]),
        .y (w_c[k-1] << 1),
        .z (w_pp[k+2]),
        .s (w_s[k]),
        .c (w_c[k])
      );
    end
  end

  assign w_cpa = {1'b0, w_s[STAGES-1]} + {1'b0, (w_c[STAGES-1] << 1)};

  // Output register: product and carry update every edge, valid is a delayed in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= {R_W{1'b0}};
      r_cout      <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_result    <= w_cpa[R_W-1:0];
      r_cout      <= w_cpa[R_W];
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cout      = r_cout;
endmodule

// File: tb/tb_csa_stage_multiplier.sv
// Directed and random checks of csa_stage_multiplier against a wide-multiply
// reference: 1-cycle latency, valid tracking, async reset behaviour.
module tb_csa_stage_multiplier;
  localparam int W   = 64;
  localparam int R_W = 2 * W + 1;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic [R_W-1:0] result;
  logic           cout;

  int n_checks;
  int n_pass;

  csa_stage_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [R_W-1:0] act, input logic [R_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic logic [R_W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [R_W-1:0] xx;
    logic [R_W-1:0] yy;
    xx = {{(R_W - W){1'b0}}, x};
    yy = {{(R_W - W){1'b0}}, y};
    return xx * yy;
  endfunction

  task automatic apply(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic v);
    a        = xa;
    b        = xb;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [R_W-1:0] exp, input logic v);
    check({tag, "_result"}, result, exp);
    check({tag, "_cout"}, {{(R_W - 1){1'b0}}, cout}, {R_W{1'b0}});
    check({tag, "_valid"}, {{(R_W - 1){1'b0}}, out_valid}, {{(R_W - 1){1'b0}}, v});
  endtask

  initial begin
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rv;
    logic [R_W-1:0] max_prod;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = 64'd0;
    b        = 64'd0;
    max_prod = 129'hFFFFFFFFFFFFFFFE0000000000000001;

    // Load a nonzero product, then assert reset asynchronously mid-cycle.
    apply(64'd120154, 64'd162134, 1'b1);
    check_out("pre_reset", 129'd19481048636, 1'b1);
    a     = 64'd5;
    b     = 64'd7;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 129'd0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_held", 129'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(64'd120154, 64'd162134, 1'b1);
    check_out("vec1", 129'd19481048636, 1'b1);
    apply(64'd127032, 64'd655352, 1'b1);
    check_out("vec2", 129'd83250675264, 1'b1);
    apply(64'd4294967295, 64'd65535, 1'b1);
    check_out("vec3", 129'd281470681677825, 1'b1);
    apply(64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    check_out("zero_a", 129'd0, 1'b1);
    apply(64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0);
    check_out("zero_b", 129'd0, 1'b0);
    apply(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    check_out("max", max_prod, 1'b1);
    check("max_msb", {{(R_W - 1){1'b0}}, result[R_W-1]}, {R_W{1'b0}});
    apply(64'd3, 64'd1, 1'b0);
    check_out("ungated", 129'd3, 1'b0);

    // Back-to-back random traffic with a reset pulse in the middle.
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 7 == 3) ra[W-1 -: 32] = 32'd0;
      rv = 1'($urandom_range(1, 0));
      if (i == 20) begin
        a        = ra;
        b        = rb;
        in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_out("rand_reset", 129'd0, 1'b0);
        #2;
        rst_n = 1'b1;
      end
      apply(ra, rb, rv);
      check_out($sformatf("rand%0d", i), ref_mul(ra, rb), rv);
      check($sformatf("rand%0d_msb", i), {{(R_W - 1){1'b0}}, result[R_W-1]}, {R_W{1'b0}});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
